pwm_ramp_ctrl: RTL and testbench

- Command-driven controller that sequences one pwm generator instance: drives its pwm_period/pwm_duty inputs and a motor direction line.
- Ramps duty toward a commanded target in fixed steps, applied only on PWM period boundaries, so the generator never sees a mid-period change.
- Direction reversal ramps duty to zero before flipping dir_out; stop commands ramp down to idle.
- Sits between the AXI register file (command source) and the pwm datapath of the smart-car motor channel.

---
 rtl/pwm_ramp_ctrl_if.sv | 19 +
 rtl/pwm_ramp_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel between the register file (master) and pwm_ramp_ctrl (slave).
interface pwm_ramp_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_period;
    logic [31:0] cmd_duty;
    logic        cmd_dir;
    logic        cmd_stop;

    modport master (
        output cmd_valid, cmd_period, cmd_duty, cmd_dir, cmd_stop,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_period, cmd_duty, cmd_dir, cmd_stop,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Ramps PWM duty toward a commanded target on period boundaries, handling direction reversal.
// Optional HOLD watchdog enabled by defining PWM_RAMP_WDT_EN.
module pwm_ramp_ctrl #(
    parameter logic [31:0] INIT_PERIOD = 32'd1000,
    parameter logic [31:0] MIN_PERIOD  = 32'd2,
    parameter logic [31:0] STEP        = 32'd50,
    parameter logic [7:0]  RAMP_DIV    = 8'd4
`ifdef PWM_RAMP_WDT_EN
    ,
    parameter logic [15:0] WDT_PERIODS = 16'd1000
`endif
) (
    input  logic           clk,
    input  logic           rst,
    pwm_ramp_ctrl_if.slave cmd,
    output logic [31:0]    pwm_period,
    output logic [31:0]    pwm_duty,
    output logic           dir_out,
    output logic           busy,
    output logic           at_target
`ifdef PWM_RAMP_WDT_EN
    ,
    output logic           wdt_trip
`endif
);

    typedef enum logic [1:0] {IDLE, RAMP, REVERSE, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] period_q, period_d, duty_q, duty_d, target_q, target_d;
    logic [31:0] nper_q, nper_d, cnt_q, cnt_d;
    logic [7:0]  div_q, div_d;
    logic        dir_q, dir_d, pdir_q, pdir_d, pend_q, pend_d;
    logic        ready_q, ready_d, busy_q, busy_d, at_q, at_d;
`ifdef PWM_RAMP_WDT_EN
    logic [15:0] wdt_q, wdt_d;
    logic        trip_q, trip_d;
`endif

    logic        boundary, upd, accept, cdir;
    logic [7:0]  div_last;
    logic [31:0] eff_tgt, diff, delta, stepped, cper, ctgt;

    always_comb begin
        div_last = (RAMP_DIV == 8'd0) ? 8'd0 : RAMP_DIV - 8'd1;
        boundary = (cnt_q == period_q - 32'd1);
        upd      = boundary && (div_q == div_last);
        accept   = cmd.cmd_valid && ready_q;
        eff_tgt  = (state_q == REVERSE) ? '0 : target_q;
        diff     = (eff_tgt >= duty_q) ? eff_tgt - duty_q : duty_q - eff_tgt;
        delta    = (diff < STEP) ? diff : STEP;
        stepped  = (eff_tgt >= duty_q) ? duty_q + delta : duty_q - delta;
        cper     = (cmd.cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd.cmd_period;
        ctgt     = cmd.cmd_stop ? '0 : ((cmd.cmd_duty < cper) ? cmd.cmd_duty : cper);
        cdir     = cmd.cmd_stop ? dir_q : cmd.cmd_dir;
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        duty_d   = duty_q;
        dir_d    = dir_q;
        target_d = target_q;
        pdir_d   = pdir_q;
        nper_d   = nper_q;
        pend_d   = pend_q;
        cnt_d    = boundary ? '0 : cnt_q + 32'd1;
        div_d    = div_q;
`ifdef PWM_RAMP_WDT_EN
        wdt_d    = wdt_q;
        trip_d   = trip_q;
`endif
        if (boundary)
            div_d = upd ? '0 : div_q + 8'd1;
        // The step always uses the target held before this cycle's command.
        if (upd && (state_q == RAMP || state_q == REVERSE))
            duty_d = stepped;
        if (boundary && pend_q) begin
            period_d = nper_q;
            pend_d   = 1'b0;
            if (duty_d > nper_q)
                duty_d = nper_q;
        end

        case (state_q)
            RAMP: begin
                if (duty_q == target_q)
                    state_d = (target_q == '0) ? IDLE : HOLD;
            end
            REVERSE: begin
                if (duty_q == '0) begin
                    dir_d   = pdir_q;
                    state_d = (target_q == '0) ? IDLE : RAMP;
                end
            end
            default: ;
        endcase

`ifdef PWM_RAMP_WDT_EN
        if (state_q == HOLD && duty_q != '0 && boundary) begin
            if (wdt_q + 16'd1 == WDT_PERIODS) begin
                wdt_d    = '0;
                trip_d   = 1'b1;
                target_d = '0;
                state_d  = RAMP;
            end else begin
                wdt_d = wdt_q + 16'd1;
            end
        end
`endif

        if (accept) begin
            nper_d   = cper;
            pend_d   = 1'b1;
            target_d = ctgt;
            pdir_d   = cdir;
`ifdef PWM_RAMP_WDT_EN
            wdt_d    = '0;
            trip_d   = 1'b0;
`endif
            // Flip immediately only if duty is zero both now and after this edge.
            if (cdir != dir_q && (duty_q != '0 || duty_d != '0)) begin
                state_d = REVERSE;
            end else begin
                dir_d   = cdir;
                state_d = (ctgt == '0 && duty_q == '0) ? IDLE : RAMP;
            end
        end

        ready_d = (state_d != REVERSE);
        busy_d  = (state_d == RAMP) || (state_d == REVERSE);
        at_d    = (duty_d == target_d) && (state_d == IDLE || state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= INIT_PERIOD;
            duty_q   <= '0;
            dir_q    <= 1'b0;
            target_q <= '0;
            pdir_q   <= 1'b0;
            nper_q   <= INIT_PERIOD;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            div_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            at_q     <= 1'b1;
`ifdef PWM_RAMP_WDT_EN
            wdt_q    <= '0;
            trip_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            dir_q    <= dir_d;
            target_q <= target_d;
            pdir_q   <= pdir_d;
            nper_q   <= nper_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            at_q     <= at_d;
`ifdef PWM_RAMP_WDT_EN
            wdt_q    <= wdt_d;
            trip_q   <= trip_d;
`endif
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign pwm_period    = period_q;
    assign pwm_duty      = duty_q;
    assign dir_out       = dir_q;
    assign busy          = busy_q;
    assign at_target     = at_q;
`ifdef PWM_RAMP_WDT_EN
    assign wdt_trip      = trip_q;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramp, reversal, stop, period clamp, coincident command.
module tb_pwm_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pwm_period;
    logic [31:0] pwm_duty;
    logic        dir_out;
    logic        busy;
    logic        at_target;
`ifdef PWM_RAMP_WDT_EN
    logic        wdt_trip;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned t_chg = 0;
    int unsigned t_prev = 0;
    int unsigned n;
    logic [31:0] exp_up[4]   = '{32'd50, 32'd100, 32'd150, 32'd200};
    logic [31:0] exp_down[4] = '{32'd150, 32'd100, 32'd50, 32'd0};

    pwm_ramp_ctrl_if cmd_if ();

    pwm_ramp_ctrl #(
        .INIT_PERIOD(32'd1000),
        .MIN_PERIOD (32'd2),
        .STEP       (32'd50),
        .RAMP_DIV   (8'd4)
`ifdef PWM_RAMP_WDT_EN
        ,
        .WDT_PERIODS(16'd3)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .pwm_period(pwm_period),
        .pwm_duty  (pwm_duty),
        .dir_out   (dir_out),
        .busy      (busy),
        .at_target (at_target)
`ifdef PWM_RAMP_WDT_EN
        ,
        .wdt_trip  (wdt_trip)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (sampling on negedges) until duty or period differs from its value at entry.
    task automatic wait_chg(input string tag, input bit sel_per, input int unsigned max_cyc);
        logic [31:0] prev;
        int unsigned k;
        prev = sel_per ? pwm_period : pwm_duty;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (((sel_per ? pwm_period : pwm_duty) === prev) && k < max_cyc);
        chk({tag, " changed in time"}, 32'((sel_per ? pwm_period : pwm_duty) !== prev), 32'd1);
        t_prev = t_chg;
        t_chg  = cyc;
    endtask

    task automatic send_cmd(input logic [31:0] per, input logic [31:0] duty,
                            input logic dir, input logic stop);
        @(negedge clk);
        chk("cmd_ready before send", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_period = per;
        cmd_if.cmd_duty   = duty;
        cmd_if.cmd_dir    = dir;
        cmd_if.cmd_stop   = stop;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_stop   = 1'b0;
    endtask

    initial begin
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_period = '0;
        cmd_if.cmd_duty   = '0;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_stop   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset pwm_period", pwm_period, 32'd1000);
        chk("reset pwm_duty", pwm_duty, 32'd0);
        chk("reset dir_out", 32'(dir_out), 32'd0);
        chk("reset cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("reset at_target", 32'(at_target), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);

        // Ramp 0 -> 200 in 50 steps, one update every 4 periods of 1000.
        send_cmd(32'd1000, 32'd200, 1'b0, 1'b0);
        chk("ramp busy", 32'(busy), 32'd1);
        chk("ramp at_target low", 32'(at_target), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_chg("ramp up", 1'b0, 5000);
            chk("ramp up duty", pwm_duty, exp_up[i]);
            if (i > 0) chk("ramp up interval", t_chg - t_prev, 32'd4000);
        end
        @(negedge clk);
        chk("hold at_target", 32'(at_target), 32'd1);
        chk("hold busy", 32'(busy), 32'd0);

        // Reverse: ramp down to 0 on dir 0, flip, ramp up to 100 on dir 1.
        send_cmd(32'd1000, 32'd100, 1'b1, 1'b0);
        chk("reverse cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
        chk("reverse busy", 32'(busy), 32'd1);
        chk("reverse dir kept", 32'(dir_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_chg("reverse down", 1'b0, 5000);
            chk("reverse down duty", pwm_duty, exp_down[i]);
            chk("reverse dir during ramp", 32'(dir_out), 32'd0);
        end
        @(negedge clk);
        chk("reverse dir flipped", 32'(dir_out), 32'd1);
        chk("reverse duty zero at flip", pwm_duty, 32'd0);
        chk("reverse ready after flip", 32'(cmd_if.cmd_ready), 32'd1);
        wait_chg("reverse up", 1'b0, 5000);
        chk("reverse up duty 50", pwm_duty, 32'd50);
        wait_chg("reverse up", 1'b0, 5000);
        chk("reverse up duty 100", pwm_duty, 32'd100);
        chk("reverse interval", t_chg - t_prev, 32'd4000);
        @(negedge clk);
        chk("reverse hold at_target", 32'(at_target), 32'd1);
        chk("reverse hold dir", 32'(dir_out), 32'd1);

        // Stop with dir 0: dir ignored, ramp 100 -> 0 at period 400, then idle.
        send_cmd(32'd400, 32'd77, 1'b0, 1'b1);
        chk("stop no reverse", 32'(cmd_if.cmd_ready), 32'd1);
        chk("stop dir kept", 32'(dir_out), 32'd1);
        wait_chg("stop down", 1'b0, 5000);
        chk("stop duty 50", pwm_duty, 32'd50);
        wait_chg("stop down", 1'b0, 5000);
        chk("stop duty 0", pwm_duty, 32'd0);
        @(negedge clk);
        chk("stop idle busy", 32'(busy), 32'd0);
        chk("stop idle at_target", 32'(at_target), 32'd1);
        chk("stop period", pwm_period, 32'd400);

        // From idle, period 1 clamps to 2, duty 5 clamps to 2; dir flips at once.
        send_cmd(32'd1, 32'd5, 1'b0, 1'b0);
        chk("clamp dir flip from idle", 32'(dir_out), 32'd0);
        chk("clamp period not yet", pwm_period, 32'd400);
        wait_chg("clamp period", 1'b1, 500);
        chk("clamp period value", pwm_period, 32'd2);
        n = 0;
        while (pwm_duty !== 32'd2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("clamp duty", pwm_duty, 32'd2);
        @(negedge clk);
        chk("clamp hold at_target", 32'(at_target), 32'd1);

        send_cmd(32'd400, 32'd0, 1'b0, 1'b1);
        wait_chg("stop from 2", 1'b0, 3000);
        chk("stop from 2 duty", pwm_duty, 32'd0);

        // Ramp toward 300; retarget to 120 on the edge of the 100 -> 150 update.
        send_cmd(32'd400, 32'd300, 1'b0, 1'b0);
        wait_chg("coincide up", 1'b0, 3000);
        chk("coincide duty 50", pwm_duty, 32'd50);
        wait_chg("coincide up", 1'b0, 3000);
        chk("coincide duty 100", pwm_duty, 32'd100);
        chk("coincide interval", t_chg - t_prev, 32'd1600);
        repeat (1599) @(posedge clk);
        #1;
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_period = 32'd400;
        cmd_if.cmd_duty   = 32'd120;
        cmd_if.cmd_dir    = 1'b0;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        t_chg = cyc;
        chk("coincide step uses old target", pwm_duty, 32'd150);
        wait_chg("coincide down", 1'b0, 3000);
        chk("coincide duty 120", pwm_duty, 32'd120);
        chk("coincide down interval", t_chg - t_prev, 32'd1600);
        @(negedge clk);
        chk("coincide hold at_target", 32'(at_target), 32'd1);
        chk("coincide hold busy", 32'(busy), 32'd0);

`ifdef PWM_RAMP_WDT_EN
        chk("wdt clear in hold", 32'(wdt_trip), 32'd0);
        n = 0;
        while (wdt_trip !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wdt trip", 32'(wdt_trip), 32'd1);
        chk("wdt ramping", 32'(busy), 32'd1);
        wait_chg("wdt down", 1'b0, 3000);
        chk("wdt duty 70", pwm_duty, 32'd70);
        wait_chg("wdt down", 1'b0, 3000);
        chk("wdt duty 20", pwm_duty, 32'd20);
        wait_chg("wdt down", 1'b0, 3000);
        chk("wdt duty 0", pwm_duty, 32'd0);
        @(negedge clk);
        chk("wdt idle", 32'(busy), 32'd0);
        send_cmd(32'd400, 32'd100, 1'b0, 1'b0);
        chk("wdt cleared by cmd", 32'(wdt_trip), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
